// File: rtl/cam_pkg.sv
// Shared camera front-end types: capture state, default geometry and the
// 12-bit RGB444 pixel that is also consumed by the HSV stage.
package cam_pkg;

  typedef enum logic [1:0] {
    SYNC,
    BLANK,
    ACTIVE
  } state_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

endpackage

// File: rtl/ov7670_rgb444_capture_edge_detect.sv
// Rise/fall pulse generator against a registered copy of the input.
// Pulses are combinational and valid in the cycle the new level is sampled.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= sig;
  end

  assign rise = sig & ~prev;
  assign fall = ~sig & prev;

endmodule

// File: rtl/ov7670_rgb444_capture.sv
// OV7670 RGB444 capture: assembles byte pairs into pixels, tags them with
// x/y and frame pulses, and flags frames whose geometry is malformed.
module ov7670_rgb444_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           capture_en,
  input  logic           cam_vsync,
  input  logic           cam_href,
  input  logic [7:0]     cam_data,
  output logic           pix_valid,
  output logic [3:0]     r,
  output logic [3:0]     g,
  output logic [3:0]     b,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_start,
  output logic           frame_end,
  output logic           frame_err
);

  // Counters carry one extra bit so they can hold exactly H_ACTIVE/V_ACTIVE.
  localparam logic [X_W:0] H_LIM = (X_W + 1)'(H_ACTIVE);
  localparam logic [Y_W:0] V_LIM = (Y_W + 1)'(V_ACTIVE);
  localparam logic [X_W:0] X_ONE = {{X_W{1'b0}}, 1'b1};
  localparam logic [Y_W:0] Y_ONE = {{Y_W{1'b0}}, 1'b1};

  state_t       state, state_next;
  logic         start_frame, end_frame;
  logic         vsync_rise, vsync_fall, href_rise, href_fall;
  logic         byte_phase, phase_eff, err_flag;
  logic [3:0]   red_latch;
  logic [X_W:0] col;
  logic [Y_W:0] row;
  pixel_t       pixel;

  edge_detect u_vsync_edge (
    .clk  (clk),
    .rst  (reset),
    .sig  (cam_vsync),
    .rise (vsync_rise),
    .fall (vsync_fall)
  );

  edge_detect u_href_edge (
    .clk  (clk),
    .rst  (reset),
    .sig  (cam_href),
    .rise (href_rise),
    .fall (href_fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SYNC;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    case (state)
      SYNC: begin
        if (vsync_rise) state_next = BLANK;
      end
      BLANK: begin
        if (vsync_fall && capture_en) begin
          state_next  = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (vsync_rise) begin
          state_next = BLANK;
          end_frame  = 1'b1;
        end
      end
      default: state_next = SYNC;
    endcase
  end

  // A line always begins on the first byte, even if a previous line was cut
  // short by VSYNC while HREF was high and left the phase dangling.
  assign phase_eff = byte_phase & ~href_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
      pixel       <= '0;
      x           <= '0;
      y           <= '0;
      byte_phase  <= 1'b0;
      red_latch   <= '0;
      col         <= '0;
      row         <= '0;
      err_flag    <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;

      if (start_frame) begin
        col        <= '0;
        row        <= '0;
        err_flag   <= 1'b0;
        byte_phase <= 1'b0;
      end else if (state == ACTIVE && !vsync_rise) begin
        if (cam_href) begin
          if (!phase_eff) begin
            red_latch  <= cam_data[3:0];
            byte_phase <= 1'b1;
          end else begin
            byte_phase <= 1'b0;
            if (col < H_LIM && row < V_LIM) begin
              pixel       <= '{r: red_latch, g: cam_data[7:4], b: cam_data[3:0]};
              x           <= col[X_W-1:0];
              y           <= row[Y_W-1:0];
              pix_valid   <= 1'b1;
              frame_start <= (col == '0) && (row == '0);
            end else begin
              err_flag <= 1'b1;
            end
            if (col != H_LIM) col <= col + X_ONE;
          end
        end else if (href_fall) begin
          if (col != H_LIM || byte_phase) err_flag <= 1'b1;
          col        <= '0;
          byte_phase <= 1'b0;
          if (row != V_LIM) row <= row + Y_ONE;
        end
      end

      if (end_frame) begin
        frame_end <= 1'b1;
        frame_err <= err_flag || (row != V_LIM);
      end
    end
  end

  assign r = pixel.r;
  assign g = pixel.g;
  assign b = pixel.b;

endmodule

// File: tb/tb_ov7670_rgb444_capture.sv
// Randomized directed bench for ov7670_rgb444_capture with a line-level
// reference model of the expected pixel stream and frame pulses.
module tb_ov7670_rgb444_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int XW = 2;
  localparam int YW = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          capture_en;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_data;
  logic          pix_valid;
  logic [3:0]    r, g, b;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          frame_start, frame_end, frame_err;

  ov7670_rgb444_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .X_W(XW), .Y_W(YW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .capture_en  (capture_en),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .pix_valid   (pix_valid),
    .r           (r),
    .g           (g),
    .b           (b),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    r;
    logic [3:0]    g;
    logic [3:0]    b;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          fs;
  } pix_t;

  pix_t exp_pix[$];
  pix_t obs_pix[$];
  logic exp_end[$];
  logic obs_end[$];

  int   checks = 0;
  int   errors = 0;
  int   viol   = 0;
  logic pv_d   = 1'b0;

  // Reference model state: is a frame being captured, rows seen, error seen.
  bit   model_active = 0;
  int   model_row    = 0;
  bit   model_err    = 0;

  int   lens[7] = '{8, 8, 8, 7, 9, 10, 6};

  always @(negedge clk) begin
    if (pix_valid) obs_pix.push_back('{r, g, b, x, y, frame_start});
    if (pix_valid && pv_d) viol++;
    if (frame_start && !pix_valid) viol++;
    if (frame_err && !frame_end) viol++;
    if (frame_end) obs_end.push_back(frame_err);
    pv_d = pix_valid;
  end

  task automatic vsync_pulse();
    @(negedge clk);
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    if (model_active) begin
      exp_end.push_back(model_err || (model_row != V));
      model_active = 0;
    end
    repeat (4) @(negedge clk);
    cam_vsync = 1'b0;
    if (capture_en) begin
      model_active = 1;
      model_row    = 0;
      model_err    = 0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic send_line(input int nbytes, input bit fixed);
    logic [3:0] red;
    logic [7:0] d;
    red = 4'h0;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      if (fixed) d = (i % 2 == 1) ? 8'h5C : 8'h0A;
      else       d = 8'($urandom);
      cam_href = 1'b1;
      cam_data = d;
      if (model_active) begin
        if (i % 2 == 0) red = d[3:0];
        else if ((i / 2) < H && model_row < V)
          exp_pix.push_back('{red, d[7:4], d[3:0], XW'(i / 2), YW'(model_row),
                              (i / 2 == 0) && (model_row == 0)});
        else model_err = 1;
      end
    end
    @(negedge clk);
    cam_href = 1'b0;
    cam_data = 8'($urandom);
    if (model_active) begin
      if (nbytes != 2 * H) model_err = 1;
      if (model_row < V) model_row++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    int n;
    repeat (4) @(negedge clk);
    checks++;
    assert (obs_pix.size() === exp_pix.size()) else begin
      errors++;
      $error("FAIL %s pix_count observed=%0d expected=%0d", tag, obs_pix.size(), exp_pix.size());
    end
    n = (obs_pix.size() < exp_pix.size()) ? obs_pix.size() : exp_pix.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      assert (obs_pix[i] === exp_pix[i]) else begin
        errors++;
        $error("FAIL %s pix[%0d] observed=%h expected=%h (r,g,b,x,y,fs)", tag, i, obs_pix[i], exp_pix[i]);
      end
    end
    checks++;
    assert (obs_end.size() === exp_end.size()) else begin
      errors++;
      $error("FAIL %s frame_end_count observed=%0d expected=%0d", tag, obs_end.size(), exp_end.size());
    end
    n = (obs_end.size() < exp_end.size()) ? obs_end.size() : exp_end.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      assert (obs_end[i] === exp_end[i]) else begin
        errors++;
        $error("FAIL %s frame_err[%0d] observed=%0b expected=%0b", tag, i, obs_end[i], exp_end[i]);
      end
    end
    checks++;
    assert (viol === 0) else begin
      errors++;
      $error("FAIL %s pulse_rules observed=%0d violations expected=0", tag, viol);
    end
    $display("frame %s: pixels=%0d ends=%0d", tag, exp_pix.size(), exp_end.size());
    exp_pix.delete();
    obs_pix.delete();
    exp_end.delete();
    obs_end.delete();
    viol = 0;
  endtask

  initial begin
    int nl;
    reset      = 1'b1;
    capture_en = 1'b1;
    cam_vsync  = 1'b0;
    cam_href   = 1'b0;
    cam_data   = 8'h00;
    #12;
    checks++;
    assert ({pix_valid, r, g, b, x, y, frame_start, frame_end, frame_err} === '0) else begin
      errors++;
      $error("FAIL reset_state observed=%h expected=0",
             {pix_valid, r, g, b, x, y, frame_start, frame_end, frame_err});
    end
    @(negedge clk);
    reset = 1'b0;

    // Activity before any VSYNC edge must not be captured.
    send_line(8, 0);
    send_line(8, 0);
    check_frame("mid_frame_start");

    // Basic frame with the fixed byte pattern.
    vsync_pulse();
    send_line(8, 1);
    send_line(8, 1);
    vsync_pulse();
    check_frame("basic");

    // Over-long line, then odd-length line.
    send_line(10, 0);
    send_line(8, 0);
    vsync_pulse();
    check_frame("long_line");
    send_line(7, 0);
    send_line(8, 0);
    vsync_pulse();
    check_frame("odd_line");

    // Short and tall frames.
    send_line(8, 0);
    vsync_pulse();
    check_frame("short_frame");
    send_line(8, 0);
    send_line(8, 0);
    send_line(8, 0);
    vsync_pulse();
    check_frame("tall_frame");

    // Dropping capture_en mid-frame only takes effect at the next VSYNC fall.
    send_line(8, 0);
    capture_en = 1'b0;
    send_line(8, 0);
    vsync_pulse();
    send_line(8, 0);
    send_line(8, 0);
    check_frame("capture_off");
    capture_en = 1'b1;
    vsync_pulse();
    send_line(8, 0);
    send_line(8, 0);
    vsync_pulse();
    check_frame("capture_on");

    // Random frame shapes.
    for (int k = 0; k < 6; k++) begin
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) send_line(lens[$urandom_range(0, 6)], 0);
      vsync_pulse();
      check_frame($sformatf("random%0d", k));
    end

    // Asynchronous reset in the middle of a line.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = 8'($urandom);
    end
    @(posedge clk);
    #2;
    checks++;
    assert ({pix_valid, x, y} === {1'b1, 2'd1, 1'b0}) else begin
      errors++;
      $error("FAIL pre_reset_pixel observed=%b expected=%b", {pix_valid, x, y}, {1'b1, 2'd1, 1'b0});
    end
    reset = 1'b1;
    #1;
    checks++;
    assert ({pix_valid, r, g, b, x, y, frame_start, frame_end, frame_err} === '0) else begin
      errors++;
      $error("FAIL async_reset observed=%h expected=0",
             {pix_valid, r, g, b, x, y, frame_start, frame_end, frame_err});
    end
    model_active = 0;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    cam_href = 1'b0;
    repeat (2) @(negedge clk);
    exp_pix.delete();
    obs_pix.delete();
    exp_end.delete();
    obs_end.delete();
    viol = 0;

    send_line(8, 0);
    send_line(8, 0);
    check_frame("after_reset_idle");
    vsync_pulse();
    send_line(8, 1);
    send_line(8, 0);
    vsync_pulse();
    check_frame("after_reset_frame");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov7670_rgb444_capture.md
Name: ov7670_rgb444_capture

Overview:
- Camera front end.
- Samples the OV7670 parallel bus (VSYNC, HREF, 8-bit data) in RGB444 mode and assembles two bytes per pixel into 4-bit r/g/b.
- Tags each pixel with x/y coordinates and frame-boundary pulses, and feeds the combinational RGB-to-HSV stage directly downstream.
- Also checks frame geometry and flags malformed frames.

Parameters:
- H_ACTIVE, 640, pixels per line expected from the camera
- V_ACTIVE, 480, lines per frame expected
- X_W, 10, x coordinate width, must satisfy 2**X_W >= H_ACTIVE
- Y_W, 9, y coordinate width, must satisfy 2**Y_W >= V_ACTIVE

Ports:
- clk  in  1  camera pixel clock (PCLK); all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- capture_en  in  1  enable capture; sampled only at frame start
- cam_vsync  in  1  camera VSYNC; high = vertical blanking
- cam_href  in  1  camera HREF; high = active line bytes
- cam_data  in  8  camera data byte
- pix_valid  out  1  one-cycle strobe; r/g/b/x/y valid
- r  out  4  red
- g  out  4  green
- b  out  4  blue
- x  out  X_W  column of current pixel, 0..H_ACTIVE-1
- y  out  Y_W  row of current pixel, 0..V_ACTIVE-1
- frame_start  out  1  high with pix_valid on pixel (0,0) only
- frame_end  out  1  one-cycle pulse on VSYNC rising edge after a captured frame
- frame_err  out  1  one-cycle pulse coincident with frame_end if geometry was wrong

Behaviour:
- Reset is asynchronous and active-high. It clears all of the following:
  - outputs: pix_valid, r, g, b, x, y, frame_start, frame_end, frame_err all 0
  - state goes to SYNC, byte_phase=0, counters 0, error flag 0, previous vsync/href registers 0
- Edge detection uses registered previous values of cam_vsync and cam_href, sampled every clk.
- States:
  - SYNC: wait for a VSYNC rising edge so capture never begins mid-frame. On the edge go to BLANK.
  - BLANK: vertical blanking. On VSYNC falling edge: if capture_en=1 go to ACTIVE and clear counters/error flag; else stay in BLANK.
  - ACTIVE: capture lines. On VSYNC rising edge go to BLANK, pulse frame_end, and pulse frame_err if the error flag is set or the line count != V_ACTIVE.
- Byte assembly, in ACTIVE with cam_href=1:
  - byte_phase=0: latch cam_data[3:0] as red; upper nibble ignored; toggle the phase.
  - byte_phase=1: on the same edge, register r=latched red, g=cam_data[7:4], b=cam_data[3:0], x=col, y=row; pix_valid=1 the following cycle; col increments.
  - Latency: pix_valid is high exactly one cycle, in the cycle after the edge that sampled the second byte. It is never high on consecutive cycles.
- Line handling:
  - On an HREF falling edge in ACTIVE: row increments; col and byte_phase clear.
  - If col != H_ACTIVE or byte_phase=1 at that edge, set the error flag.
- Overflow:
  - Pixels with col >= H_ACTIVE or row >= V_ACTIVE are not emitted (no pix_valid) and set the error flag.
  - col and row saturate; they never wrap.
- frame_start: high only together with the pix_valid for x=0, y=0.
- Deasserting capture_en mid-frame has no effect until the next VSYNC falling edge.
- VSYNC rising mid-line: go to BLANK immediately; frame_err=1, since the line count is short.
- cam_href high while in SYNC or BLANK is ignored.
- Reset mid-frame returns to SYNC; the partial frame is discarded with no frame_end.

Decomposition:
- Shared package cam_pkg holds:
  - state enum {SYNC, BLANK, ACTIVE}
  - default H_ACTIVE/V_ACTIVE constants
  - a pixel struct {r,g,b} of 4-bit fields, reused by the HSV stage
- One sub-module: edge_detect (rise/fall pulses with registered previous value), instantiated for VSYNC and HREF.
- Everything else stays in this module.

Test Plan:
- Reset, then VSYNC pulse, then 2 lines of 4 pixels with H_ACTIVE=4, V_ACTIVE=2. Bytes 0x0A,0x5C per pixel -> 8 pix_valid strobes with r=A, g=5, b=C; x=0..3, y=0..1; frame_start on first strobe only; frame_end at next VSYNC rise; frame_err=0.
- Capture starts mid-frame (HREF activity before first VSYNC rise) -> no pix_valid until after a VSYNC rise then fall.
- Line with 5 pixels (H_ACTIVE=4) -> 4 strobes on that line, 5th suppressed; frame_err=1 at frame_end.
- Line with odd byte count (7 bytes) -> 3 strobes; frame_err=1; next line restarts at x=0 with byte_phase=0.
- capture_en=0 at VSYNC fall -> whole frame ignored, no frame_end. capture_en=1 before next fall -> next frame captured normally.
- Reset asserted asynchronously mid-line -> all outputs 0 immediately. After release, no capture until a VSYNC rise/fall pair.
